// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receive engine.
//   Synchronises the Rx line, samples each bit with a 2-of-3 majority vote around the bit
//   centre, decodes 7/8 data bits with optional parity and 1/2 stop bits, flags break frames
//   and queues received characters in a show-ahead FIFO.
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx_in      asynchronous serial line, idle high
//   i_baud_val   clk cycles per oversample tick (0 behaves as 1)
//   i_parity_en  parity bit follows data
//   i_bit8_en    8 data bits (else 7)
//   i_odd_en     odd parity (else even)
//   i_stop2_en   two stop bits checked
//   i_rd_strb    pop FIFO head, clear sticky flags
//   o_rx_out     FIFO head data, 0 when empty
//   o_rx_rdy     FIFO not empty
//   o_p_err      parity error of head entry
//   o_frm_err    framing error of head entry
//   o_ov_err     sticky: frame dropped on full FIFO
//   o_brk_det    sticky: break frame seen
//   o_fifo_cnt   entries held, 0..FIFO_DEPTH
module uart_rx_ovs #(
  parameter int unsigned BAUD_W     = 18,
  parameter int unsigned OVS        = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_STG   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx_in,
  input  logic [BAUD_W-1:0]             i_baud_val,
  input  logic                          i_parity_en,
  input  logic                          i_bit8_en,
  input  logic                          i_odd_en,
  input  logic                          i_stop2_en,
  input  logic                          i_rd_strb,
  output logic [7:0]                    o_rx_out,
  output logic                          o_rx_rdy,
  output logic                          o_p_err,
  output logic                          o_frm_err,
  output logic                          o_ov_err,
  output logic                          o_brk_det,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int unsigned OVS_W = $clog2(OVS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [OVS_W-1:0] SampA   = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] SampB   = OVS_W'(OVS / 2);
  localparam logic [OVS_W-1:0] SampC   = OVS_W'(OVS / 2 + 1);
  localparam logic [OVS_W-1:0] OvsLast = OVS_W'(OVS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;

  state_e r_state, w_state_d;

  // Line synchroniser and start-edge detect
  logic [SYNC_STG-1:0] r_sync;
  logic                r_rx_prev;
  logic                w_rx;
  logic                w_start;

  assign w_rx    = r_sync[SYNC_STG-1];
  assign w_start = (r_state == StIdle) && r_rx_prev && !w_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STG-2:0], i_rx_in};
      r_rx_prev <= w_rx;
    end
  end

  // Frame configuration, frozen at the start edge
  logic [BAUD_W-1:0] r_baud;
  logic              r_parity_en, r_bit8_en, r_odd_en, r_stop2_en;

  // Oversample tick generator
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BAUD_W-1:0] w_baud_cfg;
  logic [BAUD_W-1:0] w_baud_lim;
  logic              w_tick;
  logic [OVS_W-1:0]  r_ovs_cnt;

  assign w_baud_cfg = (r_state == StIdle) ? i_baud_val : r_baud;
  assign w_baud_lim = (w_baud_cfg == '0) ? '0 : w_baud_cfg - BAUD_W'(1);
  // >= keeps the counter bounded if the divisor shrinks while running
  assign w_tick     = (r_baud_cnt >= w_baud_lim);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud_cnt <= '0;
      r_ovs_cnt  <= '0;
    end else if (w_start) begin
      r_baud_cnt <= '0;
      r_ovs_cnt  <= '0;
    end else if (w_tick) begin
      r_baud_cnt <= '0;
      r_ovs_cnt  <= (r_ovs_cnt == OvsLast) ? '0 : r_ovs_cnt + OVS_W'(1);
    end else begin
      r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
    end
  end

  // Majority vote: first two samples stored, third taken live
  logic [1:0] r_vote;
  logic       w_samp_c, w_bit_end, w_maj;

  assign w_samp_c  = w_tick && (r_ovs_cnt == SampC);
  assign w_bit_end = w_tick && (r_ovs_cnt == OvsLast);
  assign w_maj     = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx) | (r_vote[1] & w_rx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vote <= '0;
    end else if (w_tick && (r_ovs_cnt == SampA)) begin
      r_vote[0] <= w_rx;
    end else if (w_tick && (r_ovs_cnt == SampB)) begin
      r_vote[1] <= w_rx;
    end
  end

  // Frame datapath
  logic [7:0] r_data;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_par_bit;
  logic       r_frm_acc;
  logic       w_last_data, w_last_stop, w_par_err, w_brk_cond;

  assign w_last_data = (r_bit_idx == (r_bit8_en ? 3'd7 : 3'd6));
  assign w_last_stop = !r_stop2_en || r_stop_idx;
  assign w_par_err   = r_parity_en & ((^r_data) ^ r_par_bit ^ r_odd_en);
  // Break is judged only on the first stop sample
  assign w_brk_cond  = (r_data == 8'h00) && !(r_parity_en && r_par_bit) && !w_maj &&
                       !r_stop_idx;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_d = StStart;
      StStart: begin
        if (w_samp_c && w_maj) w_state_d = StIdle;
        else if (w_bit_end)    w_state_d = StData;
      end
      StData:   if (w_bit_end && w_last_data) w_state_d = r_parity_en ? StParity : StStop;
      StParity: if (w_bit_end) w_state_d = StStop;
      StStop: begin
        if (w_samp_c && w_brk_cond)       w_state_d = StBrk;
        else if (w_samp_c && w_last_stop) w_state_d = StIdle;
      end
      StBrk:    if (w_rx) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // FSM: decoded strobes
  logic w_data_smp, w_par_smp, w_stop_smp, w_push_set, w_brk_set;

  always_comb begin
    w_data_smp = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    w_push_set = 1'b0;
    w_brk_set  = 1'b0;
    unique case (r_state)
      StData:   w_data_smp = w_samp_c;
      StParity: w_par_smp  = w_samp_c;
      StStop: begin
        w_stop_smp = w_samp_c;
        w_brk_set  = w_samp_c && w_brk_cond;
        w_push_set = w_samp_c && !w_brk_cond && w_last_stop;
      end
      default: ;
    endcase
  end

  logic       r_push_vld;
  logic [9:0] r_push_ent;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud      <= '0;
      r_parity_en <= 1'b0;
      r_bit8_en   <= 1'b0;
      r_odd_en    <= 1'b0;
      r_stop2_en  <= 1'b0;
      r_data      <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_par_bit   <= 1'b0;
      r_frm_acc   <= 1'b0;
      r_push_vld  <= 1'b0;
      r_push_ent  <= '0;
    end else begin
      r_push_vld <= w_push_set;
      if (w_push_set) r_push_ent <= {r_frm_acc | ~w_maj, w_par_err, r_data};
      if (w_start) begin
        r_baud      <= i_baud_val;
        r_parity_en <= i_parity_en;
        r_bit8_en   <= i_bit8_en;
        r_odd_en    <= i_odd_en;
        r_stop2_en  <= i_stop2_en;
        r_data      <= '0;
        r_bit_idx   <= '0;
        r_stop_idx  <= 1'b0;
        r_par_bit   <= 1'b0;
        r_frm_acc   <= 1'b0;
      end else begin
        if (w_data_smp) r_data[r_bit_idx] <= w_maj;
        if (w_par_smp)  r_par_bit <= w_maj;
        if (w_stop_smp) r_frm_acc <= r_frm_acc | ~w_maj;
        if ((r_state == StData) && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
        if ((r_state == StStop) && w_bit_end) r_stop_idx <= 1'b1;
      end
    end
  end

  // Receive FIFO: entry = {frm_err, p_err, data}
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_empty, w_full, w_pop, w_push, w_ovf;
  logic [9:0]       w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop   = i_rd_strb && !w_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign w_push  = r_push_vld && (!w_full || w_pop);
  assign w_ovf   = r_push_vld && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_push_ent;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      o_ov_err  <= 1'b0;
      o_brk_det <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_ovf)          o_ov_err <= 1'b1;
      else if (i_rd_strb) o_ov_err <= 1'b0;
      if (w_brk_set)      o_brk_det <= 1'b1;
      else if (i_rd_strb) o_brk_det <= 1'b0;
    end
  end

  assign w_head     = w_empty ? 10'h000 : r_mem[r_rd_ptr];
  assign o_rx_out   = w_head[7:0];
  assign o_p_err    = w_head[8];
  assign o_frm_err  = w_head[9];
  assign o_rx_rdy   = !w_empty;
  assign o_fifo_cnt = r_cnt;

endmodule
